// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int WORD = 64
);
    logic            req_valid;
    logic            req_write;
    logic [WORD-1:0] req_addr;
    logic [WORD-1:0] req_wdata;
    logic            req_ready;
    logic            resp_valid;
    logic [WORD-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle doubleword data memory: one request in flight, fixed latency,
// single-cycle registered response with read data and an error flag.
module dmem_responder #(
    parameter int WORD      = 64,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int         DEPTH  = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [WORD-1:0] addr_q, addr_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic            err_q, err_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [WORD-1:0] rdata_q, rdata_d;
    logic            resp_err_q, resp_err_d;

    logic                 enter_resp;
    logic                 addr_err;
    logic [ADDR_BITS-1:0] idx;

    logic [WORD-1:0] mem_q [DEPTH];
    logic [WORD-1:0] rd_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // addr_d/wdata_d already hold the latched request on the entering edge,
        // including the LATENCY=1 case where latching and entry coincide.
        enter_resp = (state_d == RESP) && (state_q != RESP);
        idx        = addr_d[ADDR_BITS+2:3];
        addr_err   = (addr_d[2:0] != 3'b000) || (addr_d[WORD-1:ADDR_BITS+3] != '0);
        err_d      = enter_resp ? addr_err : err_q;

        // Ready stays low for the idle cycle right after RESP.
        ready_d = (state_q == IDLE) && (state_d == IDLE);
        valid_d = (state_q == RESP);
        if (state_q == RESP) begin
            resp_err_d = err_q;
            rdata_d    = (write_q || err_q) ? '0 : rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else if (enter_resp && !addr_err) begin
            if (write_d) begin
                mem_q[idx] <= wdata_d;
            end else begin
                rd_q <= mem_q[idx];
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: a LATENCY=2 instance driven through
// the queue/monitor pair, plus a LATENCY=1 instance checked cycle by cycle.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if #(.WORD(64)) bus ();
    dmem_responder_if #(.WORD(64)) bus1 ();

    dmem_responder #(.WORD(64), .ADDR_BITS(8), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    dmem_responder #(.WORD(64), .ADDR_BITS(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [63:0] rdata;
        logic        err;
        int unsigned at;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response pulse, also checks timing.
    always @(negedge clk) begin
        if (prev_valid) check("resp_pulse_width", 64'(bus.resp_valid), 64'd0);
        if (bus.resp_valid === 1'b1 && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d, expected no response", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("resp %s: rdata=0x%0h err=%0b cycle=%0d", mon_e.name,
                         bus.resp_rdata, bus.resp_err, cyc);
                check({mon_e.name, "_rdata"}, bus.resp_rdata, mon_e.rdata);
                check({mon_e.name, "_err"}, 64'(bus.resp_err), 64'(mon_e.err));
                check({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.at));
            end
        end
        prev_valid = bus.resp_valid;
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: req_ready=%b, expected 1", name, bus.req_ready);
        end
    endtask

    // Called at a negedge; acceptance is on the next posedge, response two edges later.
    task automatic issue(input string name, input logic w, input logic [63:0] a,
                         input logic [63:0] d, input logic [63:0] erd, input logic eerr);
        wait_ready(name);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        exp_q.push_back('{name, erd, eerr, cyc + 3});
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic l1_txn(input string name, input logic w, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] erd);
        bus1.req_valid = 1'b1;
        bus1.req_write = w;
        bus1.req_addr  = a;
        bus1.req_wdata = d;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        check({name, "_valid_n"}, 64'(bus1.resp_valid), 64'd0);
        check({name, "_ready_n"}, 64'(bus1.req_ready), 64'd0);
        @(negedge clk);
        $display("resp %s: rdata=0x%0h err=%0b cycle=%0d", name, bus1.resp_rdata, bus1.resp_err, cyc);
        check({name, "_valid_n1"}, 64'(bus1.resp_valid), 64'd1);
        check({name, "_rdata_n1"}, bus1.resp_rdata, erd);
        check({name, "_err_n1"}, 64'(bus1.resp_err), 64'd0);
        check({name, "_ready_n1"}, 64'(bus1.req_ready), 64'd0);
        @(negedge clk);
        check({name, "_valid_n2"}, 64'(bus1.resp_valid), 64'd0);
        check({name, "_ready_n2"}, 64'(bus1.req_ready), 64'd1);
    endtask

    initial begin
        int unsigned t0;
        int n;
        bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_rdata", bus.resp_rdata, 64'd0);
        check("rst_err", 64'(bus.resp_err), 64'd0);
        check("rst_l1_ready", 64'(bus1.req_ready), 64'd1);
        check("rst_l1_valid", 64'(bus1.resp_valid), 64'd0);

        issue("st_10", 1'b1, 64'h10, 64'h1234, 64'h0, 1'b0);
        issue("ld_10", 1'b0, 64'h10, 64'h0, 64'h1234, 1'b0);
        issue("ld_18", 1'b0, 64'h18, 64'h0, 64'h0, 1'b0);
        issue("ld_13_misalign", 1'b0, 64'h13, 64'h0, 64'h0, 1'b1);
        issue("st_800_range", 1'b1, 64'h800, 64'hFFFF, 64'h0, 1'b1);
        issue("ld_0_noalias", 1'b0, 64'h0, 64'h0, 64'h0, 1'b0);
        issue("st_7f8_top", 1'b1, 64'h7F8, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0);
        issue("ld_7f8_top", 1'b0, 64'h7F8, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0);
        issue("ld_msb_range", 1'b0, 64'h8000000000000000, 64'h0, 64'h0, 1'b1);

        // Back-to-back stores with req_valid held: accepts at t0+1, t0+4, t0+7.
        wait_ready("b2b");
        t0 = cyc;
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = 64'h0; bus.req_wdata = 64'd1;
        exp_q.push_back('{"b2b_st0", 64'h0, 1'b0, t0 + 3});
        @(negedge clk);
        bus.req_addr = 64'h8; bus.req_wdata = 64'd2;
        exp_q.push_back('{"b2b_st8", 64'h0, 1'b0, t0 + 6});
        repeat (3) @(negedge clk);
        bus.req_addr = 64'h10; bus.req_wdata = 64'd3;
        exp_q.push_back('{"b2b_st10", 64'h0, 1'b0, t0 + 9});
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b0;

        issue("b2b_ld0", 1'b0, 64'h0, 64'h0, 64'd1, 1'b0);
        issue("b2b_ld8", 1'b0, 64'h8, 64'h0, 64'd2, 1'b0);
        issue("b2b_ld10", 1'b0, 64'h10, 64'h0, 64'd3, 1'b0);

        // Reset on the edge after acceptance: no response, no write.
        wait_ready("midrst");
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = 64'h20; bus.req_wdata = 64'h55;
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", 64'(bus.req_ready), 64'd1);
        issue("midrst_ld20", 1'b0, 64'h20, 64'h0, 64'h0, 1'b0);
        issue("midrst_ld10_wiped", 1'b0, 64'h10, 64'h0, 64'h0, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);

        l1_txn("l1_st8", 1'b1, 64'h8, 64'hABCD, 64'h0);
        l1_txn("l1_ld8", 1'b0, 64'h8, 64'h0, 64'hABCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
